// File: rtl/aes_mode_engine.sv
// AES-128 block-mode engine: ECB / CBC / CTR chaining around a combinational
// encrypt-only AES core, one block per cycle with valid/ready on both sides.

// Combinational AES-128 encryption: full key schedule and ten rounds unrolled.
module aes (
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] ciphertext
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 4; i++) o[32*i +: 32] = sub_word(s[32*i +: 32]);
    return o;
  endfunction

  // Byte i of the block sits at bits [127-8i -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [127:0] st, rk;

  // Round pipeline unrolled in one combinational cone; last round skips MixColumns.
  always_comb begin
    rk = key;
    st = plaintext ^ key;
    for (int r = 1; r <= 10; r++) begin
      rk = next_key(rk, RCON[r-1]);
      st = shift_rows(sub_bytes(st));
      if (r != 10) st = mix_columns(st);
      st = st ^ rk;
    end
    ciphertext = st;
  end

endmodule

module aes_mode_engine #(
  parameter int CTR_W = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic [1:0]       cfg_mode,
  input  logic [127:0]     cfg_key,
  input  logic [127:0]     cfg_iv,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] block_count
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [1:0] M_ECB = 2'b00;
  localparam logic [1:0] M_CBC = 2'b01;
  localparam logic [1:0] M_CTR = 2'b10;
  localparam logic [1:0] M_RSV = 2'b11;

  // Bits of the counter block that take part in the CTR increment.
  localparam logic [127:0] CTR_MASK =
    (CTR_W >= 128) ? {128{1'b1}} : ((128'd1 << CTR_W) - 128'd1);

  state_t       state, state_nx;
  logic [127:0] key_r, chain_r;
  logic [1:0]   mode_r;
  logic [127:0] core_in, core_out, out_nx, ctr_inc;
  logic         start_ok, start_bad, accept, consume;

  assign start_ok  = cfg_start && (state == IDLE) && (cfg_mode != M_RSV);
  assign start_bad = cfg_start && (state == IDLE) && (cfg_mode == M_RSV);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  assign busy      = (state != IDLE);

  aes u_aes (
    .plaintext  (core_in),
    .key        (key_r),
    .ciphertext (core_out)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and input handshake; the output slot is one deep, so a block
  // can enter whenever the slot is empty or being drained this cycle.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_nx = RUN;
      RUN: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && in_last) state_nx = FLUSH;
      end
      FLUSH: if (consume) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Mode datapath: core operand select, output whitening and counter step.
  // Carries out of the counter field are dropped so the nonce bits never move.
  always_comb begin
    ctr_inc = (chain_r & ~CTR_MASK) | ((chain_r + 128'd1) & CTR_MASK);
    case (mode_r)
      M_CBC:   core_in = in_data ^ chain_r;
      M_CTR:   core_in = chain_r;
      default: core_in = in_data;
    endcase
    out_nx = (mode_r == M_CTR) ? (core_out ^ in_data) : core_out;
  end

  // Stream context, output slot, counters and status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_r       <= '0;
      chain_r     <= '0;
      mode_r      <= M_ECB;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      block_count <= '0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= start_bad;
      done    <= (state == FLUSH) && consume;
      if (start_ok) begin
        key_r       <= cfg_key;
        mode_r      <= cfg_mode;
        chain_r     <= cfg_iv;
        block_count <= '0;
      end
      if (accept) begin
        out_data    <= out_nx;
        out_last    <= in_last;
        out_valid   <= 1'b1;
        block_count <= block_count + CNT_W'(1);
        if (mode_r == M_CBC) chain_r <= core_out;
        if (mode_r == M_CTR) chain_r <= ctr_inc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_mode_engine.sv
// Directed bench for aes_mode_engine with an independent AES-128 reference
// (S-box derived from GF(2^8) inversion plus affine map).
module tb_aes_mode_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_start;
  logic [1:0]   cfg_mode;
  logic [127:0] cfg_key, cfg_iv;
  logic         cfg_err;
  logic         in_valid, in_ready, in_last;
  logic [127:0] in_data;
  logic         out_valid, out_ready, out_last;
  logic [127:0] out_data;
  logic         busy, done;
  logic [31:0]  block_count;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] K   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_mode_engine #(.CTR_W(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
    .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .block_count(block_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] y, base, e;
    y = 8'h01; base = x; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) y = gmul(y, base);
      base = gmul(base, base);
    end
    return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_ref(tmp[23:16]), sbox_ref(tmp[15:8]), sbox_ref(tmp[7:0]),
               sbox_ref(tmp[31:24])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_ref(s[i]);
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic start(input logic [1:0] m, input logic [127:0] k, input logic [127:0] iv);
    cfg_start = 1'b1; cfg_mode = m; cfg_key = k; cfg_iv = iv;
    @(posedge clk);
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  // Offers one block, waits (bounded) for acceptance, returns at the next negedge.
  task automatic send(input logic [127:0] d, input logic l);
    int n;
    in_data = d; in_last = l; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [127:0] prev, exp_blk;
  logic [127:0] bp_pt [4];
  logic [127:0] bp_ex [4];
  logic [127:0] iv_w, d;

  initial begin
    reset = 1'b0; cfg_start = 1'b0; cfg_mode = 2'b00; cfg_key = '0; cfg_iv = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd0);
    chk("rst_cfg_err", {127'd0, cfg_err}, 128'd0);
    chk("rst_block_count", {96'd0, block_count}, 128'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {127'd0, in_ready}, 128'd0);

    // ECB single-block known answer
    start(2'b00, K, '0);
    chk("ecb_busy", {127'd0, busy}, 128'd1);
    send(P, 1'b1);
    chk("ecb_out_valid", {127'd0, out_valid}, 128'd1);
    chk("ecb_out_data", out_data, KAT);
    chk("ecb_out_last", {127'd0, out_last}, 128'd1);
    chk("ecb_flush_in_ready", {127'd0, in_ready}, 128'd0);
    @(negedge clk);
    chk("ecb_done", {127'd0, done}, 128'd1);
    chk("ecb_busy_end", {127'd0, busy}, 128'd0);
    chk("ecb_count", {96'd0, block_count}, 128'd1);
    chk("ecb_out_valid_end", {127'd0, out_valid}, 128'd0);
    @(negedge clk);
    chk("ecb_done_pulse", {127'd0, done}, 128'd0);
    chk("ecb_count_hold", {96'd0, block_count}, 128'd1);

    // CBC, IV 0, two identical blocks
    start(2'b01, K, '0);
    send(P, 1'b0);
    chk("cbc_blk0", out_data, KAT);
    send(P, 1'b1);
    chk("cbc_blk1", out_data, aes_ref(P ^ KAT, K));
    chk("cbc_blk1_last", {127'd0, out_last}, 128'd1);
    @(negedge clk);
    chk("cbc_done", {127'd0, done}, 128'd1);
    chk("cbc_count", {96'd0, block_count}, 128'd2);

    // CTR, counter increments in the low 32 bits
    start(2'b10, K, P);
    send('0, 1'b0);
    chk("ctr_blk0", out_data, KAT);
    d = 128'h0123456789abcdeffedcba9876543210;
    send(d, 1'b1);
    chk("ctr_blk1", out_data, aes_ref(128'h00112233445566778899aabbccddef00, K) ^ d);
    @(negedge clk);

    // CTR wrap of the counter field, upper 96 bits fixed
    iv_w = 128'h0123456789abcdef01234567ffffffff;
    start(2'b10, K, iv_w);
    send(P, 1'b0);
    chk("ctrw_blk0", out_data, aes_ref(iv_w, K) ^ P);
    send(P, 1'b0);
    chk("ctrw_blk1", out_data, aes_ref(128'h0123456789abcdef0123456700000000, K) ^ P);
    send(K, 1'b1);
    chk("ctrw_blk2", out_data, aes_ref(128'h0123456789abcdef0123456700000001, K) ^ K);
    @(negedge clk);

    // Backpressure on a 4-block CBC stream
    prev = 128'hdeadbeef00000000cafef00d12345678;
    for (int i = 0; i < 4; i++) begin
      bp_pt[i] = P ^ {32'(i), 96'd0} ^ {96'd0, 32'(i * 7 + 1)};
      bp_ex[i] = aes_ref(bp_pt[i] ^ prev, K);
      prev = bp_ex[i];
    end
    start(2'b01, K, 128'hdeadbeef00000000cafef00d12345678);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = bp_pt[0]; in_last = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_data = bp_pt[1];
      chk("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
      chk("bp_hold_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_hold_data", out_data, bp_ex[0]);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("bp_order_data", out_data, bp_ex[k]);
      chk("bp_order_valid", {127'd0, out_valid}, 128'd1);
      if (k < 3) begin
        in_data = bp_pt[k+1];
        in_last = (k + 1 == 3);
      end else begin
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("bp_last", {127'd0, out_last}, 128'd1);
      end
      @(posedge clk);
    end
    @(negedge clk);
    chk("bp_done", {127'd0, done}, 128'd1);
    chk("bp_count", {96'd0, block_count}, 128'd4);

    // Reserved mode
    start(2'b11, K, '0);
    chk("rsv_cfg_err", {127'd0, cfg_err}, 128'd1);
    chk("rsv_busy", {127'd0, busy}, 128'd0);
    @(negedge clk);
    chk("rsv_cfg_err_pulse", {127'd0, cfg_err}, 128'd0);

    // cfg_start during RUN leaves key and counter untouched
    start(2'b10, K, 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f);
    send(P, 1'b0);
    chk("run_blk0", out_data, aes_ref(128'hf0e1d2c3b4a5968778695a4b3c2d1e0f, K) ^ P);
    start(2'b00, 128'hffeeddccbbaa99887766554433221100, '0);
    chk("run_start_no_err", {127'd0, cfg_err}, 128'd0);
    chk("run_start_busy", {127'd0, busy}, 128'd1);
    send(K, 1'b1);
    chk("run_blk1", out_data, aes_ref(128'hf0e1d2c3b4a5968778695a4b3c2d1e10, K) ^ K);
    @(negedge clk);

    // Reset mid-stream, then a fresh stream
    start(2'b01, K, 128'h11111111111111111111111111111111);
    send(P, 1'b0);
    send(K, 1'b0);
    in_valid = 1'b1; in_data = KAT; in_last = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("mid_rst_busy", {127'd0, busy}, 128'd0);
    chk("mid_rst_count", {96'd0, block_count}, 128'd0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start(2'b01, K, 128'h2222222222222222222222222222222f);
    send(P, 1'b0);
    exp_blk = aes_ref(P ^ 128'h2222222222222222222222222222222f, K);
    chk("fresh_blk0", out_data, exp_blk);
    send(P, 1'b1);
    chk("fresh_blk1", out_data, aes_ref(P ^ exp_blk, K));
    @(negedge clk);
    chk("fresh_count", {96'd0, block_count}, 128'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_mode_engine.md
Name: aes_mode_engine

Overview:
- Streaming AES-128 block-mode engine: applies ECB, CBC or CTR chaining around the team's combinational `aes` core (ports plaintext, key, ciphertext; encrypt only).
- Replaces testbench-level chaining for image encryption with synthesizable, mode-selectable, flow-controlled hardware.
- One 128-bit block per cycle, valid/ready on both sides; per-stream key/IV latched at start.

Parameters:
- CTR_W, 32: width of the low counter field incremented in CTR mode (1..128).
- CNT_W, 32: width of the block_count output.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- cfg_start  input  1  one-cycle pulse; latches cfg_mode, cfg_key, cfg_iv
- cfg_mode  input  2  00 ECB, 01 CBC, 10 CTR, 11 reserved
- cfg_key  input  128  AES key
- cfg_iv  input  128  CBC IV / CTR initial counter block
- cfg_err  output  1  one-cycle pulse: reserved mode at start
- in_valid  input  1  input block valid
- in_ready  output  1  engine accepts a block
- in_data  input  128  plaintext block
- in_last  input  1  final block of stream
- out_valid  output  1  output block valid
- out_ready  input  1  downstream accepts
- out_data  output  128  ciphertext block
- out_last  output  1  final output block
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse when last block consumed
- block_count  output  CNT_W  blocks accepted in current stream

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; key, chain and counter registers 0.
- States: IDLE, RUN, FLUSH.
- IDLE: in_ready=0. On cfg_start with mode 00/01/10: latch key and mode; chain_reg<=cfg_iv; block_count<=0; go to RUN. With mode 11: stay IDLE, pulse cfg_err.
- cfg_start outside IDLE is ignored; no cfg_err.
- RUN: in_ready = !out_valid || out_ready (one-deep output register, full throughput).
- Accept = in_valid && in_ready. Core input and output data per mode:
  - ECB: core input = in_data; out = core output.
  - CBC: core input = in_data ^ chain_reg; out = core output; chain_reg <= core output.
  - CTR: core input = chain_reg; out = core output ^ in_data; chain_reg[CTR_W-1:0] <= chain_reg[CTR_W-1:0]+1, wrapping mod 2^CTR_W; upper bits unchanged.
- On accept: out_data, out_last<=in_last, out_valid<=1 on the next edge (latency 1); block_count+1, wrapping mod 2^CNT_W.
- out_valid holds, with out_data stable, until out_ready. Simultaneous consume and accept in one cycle gives a back-to-back update.
- Accept with in_last=1 goes to FLUSH; in_ready=0 in FLUSH.
- FLUSH: when out_valid && out_ready, out_valid<=0, done pulses one cycle, state returns to IDLE.
- block_count holds its value in IDLE until the next valid cfg_start.
- in_valid is ignored in IDLE and FLUSH; no data is lost because in_ready=0.
- Reset asserted mid-stream discards the in-flight block and any chaining state immediately.

Test Plan:
- ECB, key 000102030405060708090a0b0c0d0e0f, in_data 00112233445566778899aabbccddeeff, in_last=1, out_ready=1 -> next cycle out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_last=1. Following cycle: done pulse, busy=0, block_count=1.
- CBC, same key, IV 0, two identical blocks 00112233...eeff -> block0 69c4e0d8...c55a; block1 = E(pt ^ block0), different from block0. Compare against software model. block_count=2.
- CTR, same key, IV 00112233445566778899aabbccddeeff, in_data 0 -> block0 69c4e0d8...c55a. Second core input …ccddef00. IV low word ffffffff -> next counter low word 00000000, upper 96 bits unchanged.
- Backpressure: stream of 4 blocks, out_ready held 0 for 3 cycles -> in_ready=0 after the first accept, out_data stable. On release, all 4 blocks emerge in order, matching the model.
- cfg_mode=11 start -> cfg_err one pulse, busy stays 0. cfg_start during RUN -> key/IV unchanged.
- Reset low mid-stream (after 2 of 5 blocks) -> out_valid=0, busy=0, block_count=0 at once. A new stream then produces model-correct output from the fresh IV.
